// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the ysyx_22050612 instruction fetch unit.
//   XLEN          : architectural register / address width
//   RESET_PC_DEF  : default PC loaded on reset
//   EBREAK_INST   : instruction injected on a misaligned fetch (halts execution)
//   TIMER_W       : width of the response wait counter
//   ifu_state_t   : fetch FSM states
//   sel_word      : picks the 32-bit word of a doubleword selected by pc[2]
package ysyx_22050612_pkg;

  localparam int                XLEN         = 64;
  localparam logic [XLEN-1:0]   RESET_PC_DEF = 64'h0000_0000_8000_0000;
  localparam logic [31:0]       EBREAK_INST  = 32'h0010_0073;
  localparam int                TIMER_W      = 8;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } ifu_state_t;

  function automatic logic [31:0] sel_word(input logic [XLEN-1:0] dw, input logic hi);
    return hi ? dw[63:32] : dw[31:0];
  endfunction

endpackage

// File: rtl/ysyx_22050612_ifu_timer.sv
// Saturating wait counter for the fetch unit.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_clr        : restart counting from zero (new request accepted)
//   i_inc        : one more cycle spent waiting without a response
//   o_expired    : this increment brings the count to TIMEOUT_CYC (or beyond)
module ysyx_22050612_ifu_timer
  import ysyx_22050612_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam logic [TIMER_W-1:0] LAST_BEFORE = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [TIMER_W-1:0] CNT_MAX     = {TIMER_W{1'b1}};

  logic [TIMER_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag on the increment that lands on the limit, so the sticky error is
  // visible right after the TIMEOUT_CYC-th empty wait cycle.
  assign o_expired = i_inc && (r_cnt >= LAST_BEFORE);

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem fetch at a time,
// buffers the returned instruction and hands it to execute with valid/ready.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr  : fetch request (addr = pc, doubleword read)
//   imem_rsp_valid, imem_rsp_data    : single-cycle response pulse with doubleword
//   inst_valid/ready, inst, inst_pc  : instruction toward execute
//   dnpc                             : next pc, taken on the inst handshake
//   fetch_timeout                    : sticky, no response within TIMEOUT_CYC cycles
// Optional feature macro: IFU_MISALIGN_CHECK_EN -- a pc with pc[1:0]!=0 is not
// fetched; an ebreak is presented instead and the unit parks in FAULT.
module ysyx_22050612_ifu
  import ysyx_22050612_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEF,
  parameter int              TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic [XLEN-1:0] dnpc,
  output logic            fetch_timeout
);

  ifu_state_t      r_state;
  ifu_state_t      w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_timeout;
  logic            w_misalign;
  logic            w_accept;
  logic            w_rsp_take;
  logic            w_consume;
  logic            w_wait_inc;
  logic            w_expired;

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_misalign = (r_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept   = imem_req_valid && imem_req_ready;
  // Responses only count while a request is outstanding.
  assign w_rsp_take = (r_state == WAIT) && imem_rsp_valid;
  assign w_consume  = (r_state == HOLD) && inst_ready;
  assign w_wait_inc = (r_state == WAIT) && !imem_rsp_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      REQ: begin
        if (w_misalign) begin
          w_state_nxt = FAULT;
        end else if (imem_req_ready) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT:    if (imem_rsp_valid) w_state_nxt = HOLD;
      HOLD:    if (inst_ready)     w_state_nxt = REQ;
      FAULT:   w_state_nxt = FAULT;
      default: w_state_nxt = REQ;
    endcase
  end

  // Output logic; the request is masked while reset is held so imem never
  // sees a request from a unit that is still being reset.
  always_comb begin
    imem_req_valid = rst_n && (r_state == REQ) && !w_misalign;
    inst_valid     = (r_state == HOLD) || (r_state == FAULT);
  end

  // Datapath: pc, instruction buffer, sticky timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_inst    <= '0;
      r_inst_pc <= RESET_PC;
      r_timeout <= 1'b0;
    end else begin
      if (w_rsp_take) begin
        r_inst    <= sel_word(imem_rsp_data, r_pc[2]);
        r_inst_pc <= r_pc;
      end
      if ((r_state == REQ) && w_misalign) begin
        r_inst    <= EBREAK_INST;
        r_inst_pc <= r_pc;
      end
      if (w_consume) begin
        r_pc <= dnpc;
      end
      if (w_expired) begin
        r_timeout <= 1'b1;
      end
    end
  end

  ysyx_22050612_ifu_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_accept),
    .i_inc     (w_wait_inc),
    .o_expired (w_expired)
  );

  assign imem_addr     = r_pc;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;
  assign fetch_timeout = r_timeout;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Self-checking bench for ysyx_22050612_ifu: a transaction-level model of the
// fetch unit (pending / outstanding / holding flags plus a wait count) is
// compared against the DUT every cycle, with literal expectations pinning it.
module tb_ysyx_22050612_ifu;

  localparam logic [63:0] RST_PC  = 64'h0000_0000_8000_0000;
  localparam int          TIMEOUT = 255;
`ifdef IFU_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [63:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic [63:0] dnpc;
  logic        fetch_timeout;

  int checks = 0;
  int errors = 0;
  int rsp_delay;
  bit spurious;

  // Model state
  logic [63:0] m_pc;
  bit          m_out;
  bit          m_have;
  bit          m_fault;
  logic [31:0] m_inst;
  logic [63:0] m_inst_pc;
  int          m_wait_cnt;
  bit          m_to;

  ysyx_22050612_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .dnpc           (dnpc),
    .fetch_timeout  (fetch_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_dw(input logic [63:0] addr);
    logic [63:0] base;
    base = {addr[63:3], 3'b000};
    case (base)
      64'h0000_0000_8000_0000: return 64'h0000_0013_0050_0093;
      64'h0000_0000_8000_0100: return 64'hDEAD_BEEF_00A0_0113;
      default:                 return {16'hC0DE, base[15:0], ~base[31:0]};
    endcase
  endfunction

  // Transaction-level model
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= RST_PC; m_out <= 1'b0; m_have <= 1'b0; m_fault <= 1'b0;
      m_inst <= '0; m_inst_pc <= RST_PC; m_wait_cnt <= 0; m_to <= 1'b0;
    end else if (m_have) begin
      if (inst_ready) begin
        m_pc   <= dnpc;
        m_have <= 1'b0;
      end
    end else if (m_fault) begin
      m_fault <= 1'b1;
    end else if (m_out) begin
      if (imem_rsp_valid) begin
        m_inst    <= m_pc[2] ? mem_dw(m_pc) >> 32 : mem_dw(m_pc) & 64'hFFFF_FFFF;
        m_inst_pc <= m_pc;
        m_out     <= 1'b0;
        m_have    <= 1'b1;
      end else begin
        m_wait_cnt <= m_wait_cnt + 1;
        if (m_wait_cnt + 1 >= TIMEOUT) m_to <= 1'b1;
      end
    end else if (MIS_EN && (m_pc[1:0] != 2'b00)) begin
      m_fault   <= 1'b1;
      m_inst    <= 32'h0010_0073;
      m_inst_pc <= m_pc;
    end else if (imem_req_ready) begin
      m_out      <= 1'b1;
      m_wait_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    bit exp_req, exp_iv;
    exp_req = rst_n && !m_out && !m_have && !m_fault &&
              !(MIS_EN && (m_pc[1:0] != 2'b00));
    exp_iv  = m_have || m_fault;
    chk("req_valid", {63'd0, imem_req_valid}, {63'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", {63'd0, inst_valid}, {63'd0, exp_iv});
    if (exp_iv) begin
      chk("inst", {32'd0, inst}, {32'd0, m_inst});
      chk("inst_pc", inst_pc, m_inst_pc);
    end
    chk("fetch_timeout", {63'd0, fetch_timeout}, {63'd0, m_to});
  endtask

  // One clock: drive the memory response, step, then compare on the falling edge.
  task automatic tick();
    #1;
    imem_rsp_valid = (m_out && (m_wait_cnt == rsp_delay)) || spurious;
    imem_rsp_data  = spurious ? 64'h1111_2222_3333_4444 : mem_dw(m_pc);
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic wait_have(input int bound, output int n);
    n = 0;
    while (!(m_have || m_fault) && n < bound) begin
      tick();
      n++;
    end
    if (!(m_have || m_fault)) chk("wait_inst_bound", 64'(n), 64'(bound + 1));
  endtask

  task automatic handshake(input logic [63:0] nxt);
    inst_ready = 1'b1;
    dnpc       = nxt;
    tick();
    inst_ready = 1'b0;
  endtask

  int n;

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; dnpc = '0; rsp_delay = 0; spurious = 1'b0;
    tick(); tick();
    chk("rst_inst", {32'd0, inst}, 64'd0);
    chk("rst_inst_pc", inst_pc, 64'h8000_0000);
    chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("rel_addr", imem_addr, 64'h8000_0000);

    // Zero-wait memory
    imem_req_ready = 1'b1;
    wait_have(10, n);
    chk("latency", 64'(n), 64'd2);
    chk("zw_inst0", {32'd0, inst}, 64'h0050_0093);
    chk("zw_pc0", inst_pc, 64'h8000_0000);
    handshake(64'h8000_0004);
    chk("zw_addr1", imem_addr, 64'h8000_0004);
    wait_have(10, n);
    chk("zw_inst1", {32'd0, inst}, 64'h0000_0013);

    // Backpressure with a stray response while holding
    for (int i = 0; i < 5; i++) begin
      spurious = (i == 2);
      tick();
      chk("bp_no_req", {63'd0, imem_req_valid}, 64'd0);
      chk("bp_inst", {32'd0, inst}, 64'h0000_0013);
    end
    spurious = 1'b0;

    // Redirect, with imem stalling the request for a few cycles
    imem_req_ready = 1'b0;
    handshake(64'h8000_0100);
    chk("rd_addr", imem_addr, 64'h8000_0100);
    tick(); tick(); tick();
    imem_req_ready = 1'b1;
    rsp_delay = 2;
    wait_have(20, n);
    chk("rd_inst_lo", {32'd0, inst}, 64'h00A0_0113);
    handshake(64'h8000_0104);
    wait_have(20, n);
    chk("rd_inst_hi", {32'd0, inst}, 64'hDEAD_BEEF);
    chk("rd_pc_hi", inst_pc, 64'h8000_0104);

    // Timeout, late response still accepted
    rsp_delay = 300;
    handshake(64'h8000_0200);
    tick();
    for (int i = 0; i < 254; i++) tick();
    chk("to_before", {63'd0, fetch_timeout}, 64'd0);
    tick();
    chk("to_at", {63'd0, fetch_timeout}, 64'd1);
    wait_have(100, n);
    chk("to_late_valid", {63'd0, inst_valid}, 64'd1);
    chk("to_sticky", {63'd0, fetch_timeout}, 64'd1);

    // Reset while waiting for a response
    rsp_delay = 50;
    handshake(64'h8000_0300);
    tick(); tick(); tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rw_req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("rw_addr", imem_addr, 64'h8000_0000);
    chk("rw_inst_valid", {63'd0, inst_valid}, 64'd0);
    chk("rw_timeout", {63'd0, fetch_timeout}, 64'd0);

    // Misaligned next pc
    imem_req_ready = 1'b1;
    rsp_delay = 1;
    wait_have(20, n);
    handshake(64'h8000_0002);
`ifdef IFU_MISALIGN_CHECK_EN
    chk("ma_no_req", {63'd0, imem_req_valid}, 64'd0);
    tick();
    chk("ma_inst", {32'd0, inst}, 64'h0010_0073);
    chk("ma_pc", inst_pc, 64'h8000_0002);
    inst_ready = 1'b1;
    tick(); tick(); tick();
    inst_ready = 1'b0;
    chk("ma_hold", {63'd0, inst_valid}, 64'd1);
`else
    chk("ma_addr", imem_addr, 64'h8000_0002);
    wait_have(20, n);
    chk("ma_inst", {32'd0, inst}, 64'h0050_0093);
    chk("ma_pc", inst_pc, 64'h8000_0002);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
